wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 255: load-response watchdog limit in cycles, range 1..255.
REQ-002 The block SHALL have port ACLK, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port ARESETn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port mem_valid, input, 1 bit: the MEM stage offers an instruction.
REQ-005 The block SHALL have port mem_ready, output, 1 bit: WB accepts the offer.
REQ-006 The block SHALL have the following MEM-stage input ports:
- mem_reg_wen, 1 bit: instruction writes rd.
- mem_rd_idx, 5 bits: destination register index.
- mem_wb_sel, 2 bits (wb_sel_e): 0=ALU, 1=LOAD, 2=PC4; 3 is reserved and treated as ALU.
- mem_funct3, 3 bits: load type.
- mem_addr_lo, 2 bits: byte offset of the load address.
- mem_alu_result, XLEN bits.
- mem_pc4, XLEN bits.
REQ-007 The block SHALL have the following data-memory input ports:
- dmem_rvalid, 1 bit: load response valid.
- dmem_rdata, XLEN bits: raw load word.
REQ-008 The block SHALL have the following register-file write-port outputs:
- rf_wen, 1 bit.
- rf_rd_idx, 5 bits.
- rf_rd_wdata, XLEN bits.
REQ-009 The block SHALL have port retire, output, 1 bit: one-cycle pulse per completed instruction.
REQ-010 The block SHALL have port wb_err, output, 1 bit: sticky watchdog-timeout flag.

Function
REQ-011 The state machine SHALL have three states:
- EMPTY: no instruction held.
- WAIT_LOAD: load held, awaiting dmem_rvalid.
- FULL: result ready, committing this cycle.
REQ-012 mem_ready SHALL be 1 in EMPTY and FULL and 0 in WAIT_LOAD; an instruction is accepted when mem_valid & mem_ready at a clock edge.
REQ-013 On accept, the block SHALL latch all mem_* fields; the next state is WAIT_LOAD if mem_wb_sel==LOAD, otherwise FULL with the result selected as mem_alu_result (ALU) or mem_pc4 (PC4).
REQ-014 In FULL, the block SHALL assert retire=1 and rf_wen = latched reg_wen & (rd_idx!=0); rf_rd_idx and rf_rd_wdata SHALL carry the latched values, all combinational from state.
REQ-015 From FULL, the next state SHALL be FULL on a new accept (back-to-back, one retire per cycle), else EMPTY.
REQ-016 In WAIT_LOAD with dmem_rvalid=1, the block SHALL capture the extracted load data and go FULL; load commit latency is accept + response cycle + 1.
REQ-017 Load extraction SHALL use the byte lane selected by addr_lo:
- LB (000): sign-extend the byte.
- LBU (100): zero-extend the byte.
- LH (001) / LHU (101): select the halfword by addr_lo[1], sign- or zero-extend.
- LW (010): full word.
- Any other funct3: result 0.
REQ-018 In WAIT_LOAD, a wait counter SHALL increment each cycle without dmem_rvalid; on reaching MAX_WAIT, the block SHALL set wb_err, commit data 0 and go FULL.
REQ-019 The wait counter SHALL clear on every entry to WAIT_LOAD.
REQ-020 dmem_rvalid outside WAIT_LOAD SHALL be ignored.
REQ-021 A write to x0 SHALL retire with rf_wen=0.

Reset
REQ-022 While ARESETn=0, the block SHALL hold:
- state EMPTY and wait counter 0.
- wb_err=0, rf_wen=0, rf_rd_idx=0, rf_rd_wdata=0, retire=0 and mem_ready=1.
- every forwarding output 0.
REQ-023 Reset asserted in WAIT_LOAD or FULL SHALL discard the held instruction without writing the register file.
REQ-024 wb_err SHALL clear only on reset.

Configuration
REQ-025 With WB_FWD_EN defined, the block SHALL add these outputs:
- fwd_valid (1): equals rf_wen.
- fwd_rd_idx (5): equals rf_rd_idx.
- fwd_data (XLEN): equals rf_rd_wdata.
- fwd_pending (1): state==WAIT_LOAD & reg_wen & rd!=0.
Decode uses these for same-cycle bypass and load-use stall.
REQ-026 Without WB_FWD_EN, these ports SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-027 wb_sel_e and the load funct3 encodings SHALL reside in package CPU_profile alongside XLEN.
REQ-028 Load extraction SHALL be a combinational sub-module load_extract (inputs funct3, addr_lo, rdata; output data).

Verification
REQ-029 The bench SHALL cover the ALU case: accept ALU with rd=5, alu=0x1234 -> next cycle rf_wen=1, rf_rd_idx=5, rf_rd_wdata=0x1234, retire=1.
REQ-030 The bench SHALL cover load extraction: accept LB, addr_lo=3; rvalid next cycle with rdata=0x80FF_FFFF -> following cycle wdata=0xFFFF_FF80.
- Same stimulus as LBU -> wdata=0x0000_0080.
- LHU, addr_lo=2 -> wdata=0x0000_80FF.
REQ-031 The bench SHALL cover back-to-back ALU instructions over 4 cycles: mem_ready stays 1, 4 retire pulses, and rd values are written in order.
REQ-032 The bench SHALL cover the load stall: the load is held 3 cycles without rvalid -> mem_ready=0 throughout and a concurrent mem_valid is not accepted; rvalid -> FULL, then mem_ready=1.
REQ-033 The bench SHALL cover the watchdog with MAX_WAIT=4 and no rvalid -> wb_err=1 after 4 cycles, load commits 0, and wb_err stays 1 until ARESETn=0.
REQ-034 The bench SHALL cover x0 and reset:
- ALU with rd=0 -> retire=1, rf_wen=0.
- ARESETn dropped in WAIT_LOAD -> immediate EMPTY, no rf_wen ever asserted.

Source files
------------

// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package : CPU_profile
// Purpose : Shared CPU-wide definitions used by the write-back stage: the
//           datapath width, the write-back source select encoding and the
//           load funct3 encodings.
// Rev     : 1.0  initial release
// ============================================================================
package CPU_profile;

    localparam int XLEN = 32;

    // Write-back source select; the reserved code behaves as ALU.
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_LOAD = 2'd1,
        WB_SEL_PC4  = 2'd2,
        WB_SEL_RSVD = 2'd3
    } wb_sel_e;

    // Load funct3 encodings (RV32I).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/wb_stage_load_extract.sv
`default_nettype none
// ============================================================================
// Module  : load_extract
// Purpose : Combinational load-data alignment. Picks the byte or halfword
//           lane addressed by addr_lo out of the raw memory word and sign- or
//           zero-extends it according to funct3.
// Ports   : funct3  - load type
//           addr_lo - byte offset of the load address
//           rdata   - raw word returned by data memory
//           data    - aligned, extended load result
// Rev     : 1.0  initial release
// ============================================================================
module load_extract
    import CPU_profile::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfword lane only depends on bit 1; misaligned halfwords are not
        // this stage's concern.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   data = rdata;
            default: data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : wb_stage
// Purpose : Pipeline write-back stage. Accepts one instruction per cycle from
//           MEM, waits for the data-memory response on loads (with a
//           watchdog), and drives the register-file write port for exactly
//           one cycle per retired instruction.
// Config  : define WB_FWD_EN to add the fwd_* bypass / load-use outputs.
// Ports   : ACLK, ARESETn (async assert, active-low)
//           mem_valid/mem_ready handshake + mem_* instruction fields
//           dmem_rvalid/dmem_rdata load response
//           rf_wen/rf_rd_idx/rf_rd_wdata register-file write port
//           retire (per-instruction pulse), wb_err (sticky watchdog flag)
//           fwd_valid/fwd_rd_idx/fwd_data/fwd_pending (WB_FWD_EN only)
// Rev     : 1.0  initial release
// ============================================================================
module wb_stage
    import CPU_profile::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic            mem_reg_wen,
    input  logic [4:0]      mem_rd_idx,
    input  wb_sel_e         mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pc4,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rf_wen,
    output logic [4:0]      rf_rd_idx,
    output logic [XLEN-1:0] rf_rd_wdata,
    output logic            retire,
`ifdef WB_FWD_EN
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd_idx,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_pending,
`endif
    output logic            wb_err
);

    localparam logic [1:0] ST_EMPTY     = 2'd0;
    localparam logic [1:0] ST_WAIT_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL      = 2'd2;

    // Counter value on the last tolerated idle cycle: the next idle edge
    // would make the count reach MAX_WAIT, so that edge times out instead.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [1:0]      state;
    logic            reg_wen;
    logic [4:0]      rd_idx;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] result;
    logic [7:0]      wait_cnt;
    logic            err;

    logic            accept;
    logic            timeout;
    logic            rd_live;
    logic [XLEN-1:0] load_data;

    load_extract u_load_extract (
        .funct3  (funct3),
        .addr_lo (addr_lo),
        .rdata   (dmem_rdata),
        .data    (load_data)
    );

    assign mem_ready = (state != ST_WAIT_LOAD);
    assign accept    = mem_valid & mem_ready;
    assign timeout   = (state == ST_WAIT_LOAD) & ~dmem_rvalid & (wait_cnt == WAIT_LAST);
    assign rd_live   = reg_wen & (rd_idx != 5'd0);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= ST_EMPTY;
            reg_wen  <= 1'b0;
            rd_idx   <= 5'd0;
            funct3   <= 3'd0;
            addr_lo  <= 2'd0;
            result   <= '0;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_LOAD: begin
                    // A real response wins over a timeout in the same cycle.
                    if (dmem_rvalid) begin
                        result <= load_data;
                        state  <= ST_FULL;
                    end else if (timeout) begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= ST_FULL;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    // EMPTY and FULL both accept; from FULL this gives
                    // back-to-back commits at one per cycle.
                    if (accept) begin
                        reg_wen <= mem_reg_wen;
                        rd_idx  <= mem_rd_idx;
                        funct3  <= mem_funct3;
                        addr_lo <= mem_addr_lo;
                        if (mem_wb_sel == WB_SEL_LOAD) begin
                            wait_cnt <= 8'd0;
                            state    <= ST_WAIT_LOAD;
                        end else begin
                            result <= (mem_wb_sel == WB_SEL_PC4) ? mem_pc4 : mem_alu_result;
                            state  <= ST_FULL;
                        end
                    end else begin
                        state <= ST_EMPTY;
                    end
                end
            endcase
        end
    end

    // Write port is gated by FULL so it reads as all-zero whenever nothing
    // is committing, including during reset.
    assign retire      = (state == ST_FULL);
    assign rf_wen      = retire & rd_live;
    assign rf_rd_idx   = retire ? rd_idx : 5'd0;
    assign rf_rd_wdata = retire ? result : '0;
    assign wb_err      = err;

`ifdef WB_FWD_EN
    assign fwd_valid   = rf_wen;
    assign fwd_rd_idx  = rf_rd_idx;
    assign fwd_data    = rf_rd_wdata;
    assign fwd_pending = (state == ST_WAIT_LOAD) & rd_live;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_stage
// Purpose : Self-checking bench for wb_stage (MAX_WAIT=4). A behavioural
//           model tracks the held instruction; a compare process checks all
//           outputs every cycle, and directed tests pin literal values.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wb_stage;
    import CPU_profile::*;

    localparam int MAX_WAIT = 4;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_reg_wen = 1'b0;
    logic [4:0]  mem_rd_idx = '0;
    wb_sel_e     mem_wb_sel = WB_SEL_ALU;
    logic [2:0]  mem_funct3 = '0;
    logic [1:0]  mem_addr_lo = '0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_pc4 = '0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        rf_wen;
    logic [4:0]  rf_rd_idx;
    logic [31:0] rf_rd_wdata;
    logic        retire;
    logic        wb_err;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd_idx;
    logic [31:0] fwd_data;
    logic        fwd_pending;
`endif

    wb_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_reg_wen    (mem_reg_wen),
        .mem_rd_idx     (mem_rd_idx),
        .mem_wb_sel     (mem_wb_sel),
        .mem_funct3     (mem_funct3),
        .mem_addr_lo    (mem_addr_lo),
        .mem_alu_result (mem_alu_result),
        .mem_pc4        (mem_pc4),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .rf_wen         (rf_wen),
        .rf_rd_idx      (rf_rd_idx),
        .rf_rd_wdata    (rf_rd_wdata),
        .retire         (retire),
`ifdef WB_FWD_EN
        .fwd_valid      (fwd_valid),
        .fwd_rd_idx     (fwd_rd_idx),
        .fwd_data       (fwd_data),
        .fwd_pending    (fwd_pending),
`endif
        .wb_err         (wb_err)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what instruction is held and in which phase.
    // ------------------------------------------------------------------
    localparam int P_IDLE = 0, P_LOAD = 1, P_COMMIT = 2;

    int          m_phase  = P_IDLE;
    int          m_waited = 0;
    bit          m_err    = 1'b0;
    bit          m_wen    = 1'b0;
    logic [4:0]  m_rd     = '0;
    logic [2:0]  m_f3     = '0;
    logic [1:0]  m_lo     = '0;
    logic [31:0] m_data   = '0;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] sh8;
        logic [31:0] sh16;
        sh8  = w >> (8 * lo);
        sh16 = w >> (16 * lo[1]);
        case (f3)
            3'd0:    return 32'(int'(byte'(sh8)));
            3'd4:    return sh8 & 32'hFF;
            3'd1:    return 32'(int'(shortint'(sh16)));
            3'd5:    return sh16 & 32'hFFFF;
            3'd2:    return w;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m_phase = P_IDLE; m_waited = 0; m_err = 1'b0;
            m_wen = 1'b0; m_rd = '0; m_data = '0;
        end else if (m_phase == P_LOAD) begin
            if (dmem_rvalid) begin
                m_data = ref_load(m_f3, m_lo, dmem_rdata);
                m_phase = P_COMMIT;
            end else if (m_waited + 1 >= MAX_WAIT) begin
                m_err = 1'b1; m_data = '0; m_phase = P_COMMIT;
            end else begin
                m_waited++;
            end
        end else if (mem_valid) begin
            m_wen = mem_reg_wen; m_rd = mem_rd_idx;
            if (mem_wb_sel == WB_SEL_LOAD) begin
                m_f3 = mem_funct3; m_lo = mem_addr_lo; m_waited = 0; m_phase = P_LOAD;
            end else begin
                m_data = (mem_wb_sel == WB_SEL_PC4) ? mem_pc4 : mem_alu_result;
                m_phase = P_COMMIT;
            end
        end else begin
            m_phase = P_IDLE;
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge ACLK) begin
        bit c;
        c = (m_phase == P_COMMIT);
        check("mem_ready",   32'(mem_ready),   32'(m_phase != P_LOAD));
        check("retire",      32'(retire),      32'(c));
        check("rf_wen",      32'(rf_wen),      32'(c && m_wen && m_rd != 0));
        check("rf_rd_idx",   32'(rf_rd_idx),   c ? 32'(m_rd) : 32'd0);
        check("rf_rd_wdata", rf_rd_wdata,      c ? m_data : 32'd0);
        check("wb_err",      32'(wb_err),      32'(m_err));
`ifdef WB_FWD_EN
        check("fwd_valid",   32'(fwd_valid),   32'(c && m_wen && m_rd != 0));
        check("fwd_rd_idx",  32'(fwd_rd_idx),  c ? 32'(m_rd) : 32'd0);
        check("fwd_data",    fwd_data,         c ? m_data : 32'd0);
        check("fwd_pending", 32'(fwd_pending), 32'(m_phase == P_LOAD && m_wen && m_rd != 0));
`endif
    end

    int retire_cnt = 0;
    bit watch_wen  = 1'b0;
    bit wen_seen   = 1'b0;
    always @(posedge ACLK) begin
        if (retire) retire_cnt++;
        if (watch_wen && rf_wen) wen_seen = 1'b1;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge ACLK);
        #2;
    endtask

    task automatic offer(input logic wen, input logic [4:0] rd, input wb_sel_e sel,
                         input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [31:0] pc4);
        mem_valid = 1'b1; mem_reg_wen = wen; mem_rd_idx = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_addr_lo = lo; mem_alu_result = alu; mem_pc4 = pc4;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    logic [2:0]  ld_f3  [3] = '{3'b000, 3'b100, 3'b101};
    logic [1:0]  ld_lo  [3] = '{2'd3, 2'd3, 2'd2};
    logic [31:0] ld_exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};

    initial begin
        int r0;
        // Reset state
        repeat (2) @(negedge ACLK);
        check("reset mem_ready", 32'(mem_ready), 32'd1);
        check("reset retire",    32'(retire),    32'd0);
        check("reset rf_wen",    32'(rf_wen),    32'd0);
        check("reset wdata",     rf_rd_wdata,    32'd0);
        check("reset wb_err",    32'(wb_err),    32'd0);
        cyc();
        ARESETn = 1'b1;
        cyc();

        // ALU commit
        offer(1'b1, 5'd5, WB_SEL_ALU, 3'd0, 2'd0, 32'h1234, 32'h40);
        cyc(); idle();
        @(negedge ACLK);
        check("alu rf_wen",  32'(rf_wen),    32'd1);
        check("alu rd_idx",  32'(rf_rd_idx), 32'd5);
        check("alu wdata",   rf_rd_wdata,    32'h1234);
        check("alu retire",  32'(retire),    32'd1);
        cyc();

        // PC4 select
        offer(1'b1, 5'd6, WB_SEL_PC4, 3'd0, 2'd0, 32'h1, 32'h104);
        cyc(); idle();
        @(negedge ACLK);
        check("pc4 wdata", rf_rd_wdata, 32'h104);
        cyc();

        // Load extraction
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 5'(10 + i), WB_SEL_LOAD, ld_f3[i], ld_lo[i], 32'h0, 32'h0);
            cyc();
            mem_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FFFF;
            cyc();
            dmem_rvalid = 1'b0;
            @(negedge ACLK);
            check("load wdata",  rf_rd_wdata,    ld_exp[i]);
            check("load retire", 32'(retire),    32'd1);
            cyc();
        end

        // Back-to-back ALU
        r0 = retire_cnt;
        for (int k = 1; k <= 4; k++) begin
            offer(1'b1, 5'(k), WB_SEL_ALU, 3'd0, 2'd0, 32'h100 + 32'(k), 32'h0);
            cyc();
            @(negedge ACLK);
            check("b2b mem_ready", 32'(mem_ready), 32'd1);
            check("b2b rd order",  32'(rf_rd_idx), 32'(k));
        end
        idle();
        cyc();
        check("b2b retire count", 32'(retire_cnt - r0), 32'd4);

        // Load stall with a competing offer
        offer(1'b1, 5'd7, WB_SEL_LOAD, 3'b010, 2'd0, 32'h0, 32'h0);
        cyc();
        offer(1'b1, 5'd9, WB_SEL_ALU, 3'd0, 2'd0, 32'h99, 32'h0);
        for (int w = 0; w < 3; w++) begin
            @(negedge ACLK);
            check("stall mem_ready", 32'(mem_ready), 32'd0);
            check("stall retire",    32'(retire),    32'd0);
            cyc();
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        cyc();
        dmem_rvalid = 1'b0;
        @(negedge ACLK);
        check("stall load idx",  32'(rf_rd_idx), 32'd7);
        check("stall load data", rf_rd_wdata,    32'hDEAD_BEEF);
        check("stall ready",     32'(mem_ready), 32'd1);
        cyc(); idle();
        @(negedge ACLK);
        check("stall next idx", 32'(rf_rd_idx), 32'd9);
        check("stall next data", rf_rd_wdata,   32'h99);
        cyc();

        // Watchdog
        offer(1'b1, 5'd3, WB_SEL_LOAD, 3'b010, 2'd0, 32'h0, 32'h0);
        cyc(); idle();
        for (int w = 0; w < 4; w++) begin
            @(negedge ACLK);
            check("wd early err", 32'(wb_err), 32'd0);
            cyc();
        end
        @(negedge ACLK);
        check("wd err",    32'(wb_err),  32'd1);
        check("wd retire", 32'(retire),  32'd1);
        check("wd data",   rf_rd_wdata,  32'd0);
        repeat (3) cyc();
        check("wd sticky", 32'(wb_err), 32'd1);

        // x0 destination
        offer(1'b1, 5'd0, WB_SEL_ALU, 3'd0, 2'd0, 32'h55, 32'h0);
        cyc(); idle();
        @(negedge ACLK);
        check("x0 retire", 32'(retire), 32'd1);
        check("x0 rf_wen", 32'(rf_wen), 32'd0);
        check("x0 err still set", 32'(wb_err), 32'd1);
        cyc();

        // Reset while waiting on a load
        offer(1'b1, 5'd12, WB_SEL_LOAD, 3'b010, 2'd0, 32'h0, 32'h0);
        cyc(); idle();
        watch_wen = 1'b1;
        @(negedge ACLK);
        check("rst pre ready", 32'(mem_ready), 32'd0);
        #1 ARESETn = 1'b0;
        #1;
        check("rst ready",  32'(mem_ready), 32'd1);
        check("rst err",    32'(wb_err),    32'd0);
        check("rst retire", 32'(retire),    32'd0);
        cyc();
        ARESETn = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        repeat (2) cyc();
        idle();
        @(negedge ACLK);
        check("rst no rf_wen",  32'(wen_seen), 32'd0);
        check("rst no retire",  32'(retire),   32'd0);
        watch_wen = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
